// File: rtl/video_fx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_fx_pkg
// Description : Shared types and constants for the video effects Avalon-ST
//               adapter: config field layout, packet FSM encoding, pipeline
//               stage record and packet-type helper.
// Revision    : 1.0 - initial release
// ============================================================================
package video_fx_pkg;

    localparam int DATA_W = 16;
    localparam int BEAT_W = DATA_W + 2;   // {sop, eop, data}

    // Effect configuration layout, effect field in the MSBs
    localparam int CFG_SUBST_LSB    = 0;
    localparam int CFG_SUBST_W      = 16;
    localparam int CFG_KEYMASK_LSB  = 16;
    localparam int CFG_KEYMASK_W    = 16;
    localparam int CFG_KEY_LSB      = 32;
    localparam int CFG_KEY_W        = 16;
    localparam int CFG_QUANT_LSB    = 48;
    localparam int CFG_QUANT_W      = 2;
    localparam int CFG_DELRGB_LSB   = 50;
    localparam int CFG_DELRGB_W     = 2;
    localparam int CFG_EFFECT_LSB   = 52;
    localparam int CFG_EFFECT_W     = 5;
    localparam int CFG_W            = 57;

    localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        VIDEO    = 2'd1,
        CONTROL  = 2'd2
    } pkt_state_e;

    typedef struct packed {
        logic              valid;
        logic              sop;
        logic              eop;
        logic              bypass;
        logic [DATA_W-1:0] data;
    } stage_t;

    // Header beat carries the packet type in its low nibble
    function automatic logic is_video_type(input logic [DATA_W-1:0] hdr);
        return hdr[3:0] == PKT_TYPE_VIDEO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_effects_st_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : video_effects_st_adapter_if
// Description : One Avalon-ST link (data, sop, eop, valid, ready) carrying
//               RGB565 pixels or packet header beats.
// Revision    : 1.0 - initial release
// ============================================================================
interface video_effects_st_adapter_if;
    import video_fx_pkg::*;

    logic [DATA_W-1:0] data;
    logic              startofpacket;
    logic              endofpacket;
    logic              valid;
    logic              ready;

    modport master (
        output data, startofpacket, endofpacket, valid,
        input  ready
    );

    modport slave (
        input  data, startofpacket, endofpacket, valid,
        output ready
    );

endinterface
`default_nettype wire

// File: rtl/video_st_fifo.sv
`default_nettype none
// ============================================================================
// Module      : video_st_fifo
// Description : Synchronous FIFO for {sop, eop, data} beats. DEPTH must be a
//               power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module video_st_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; simultaneous push/pop keeps the count
    always_comb begin
        w_do_push = push && !full;
        w_do_pop  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; a reset discards any buffered beats
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful behind the occupancy count
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_effects_st_adapter.sv
`default_nettype none
// ============================================================================
// Module      : video_effects_st_adapter
// Description : Avalon-ST wrapper around the single-cycle video_effects stage.
//               Classifies packets, bypasses headers/control packets around
//               the effect, realigns sideband with the effect's registered
//               output, latches config per frame and buffers results with
//               credit-based backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module video_effects_st_adapter
    import video_fx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    video_effects_st_adapter_if.slave  sink,
    video_effects_st_adapter_if.master source,
    output logic [DATA_W-1:0]      fx_data_in,
    input  logic [DATA_W-1:0]      fx_data_out,
    input  logic [CFG_W-1:0]       cfg_in,
    output logic [CFG_W-1:0]       cfg_out,
    output logic [15:0]            dropped_beats
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] c_credit_limit = (CNT_W+1)'(FIFO_DEPTH);

    pkt_state_e        state_q, state_d;
    stage_t            s1_q, s1_d;
    stage_t            s2_q, s2_d;
    logic [DATA_W-1:0] fx_data_in_q, fx_data_in_d;
    logic [CFG_W-1:0]  cfg_q, cfg_d;
    logic [15:0]       drop_q, drop_d;
    logic              ready_en_q, ready_en_d;

    logic              w_accept;
    logic              w_sink_ready;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [CNT_W:0]    w_credit_sum;
    logic [BEAT_W-1:0] w_fifo_wr_data;
    logic [BEAT_W-1:0] w_fifo_rd_data;
    logic              w_fifo_pop;

    // Every beat in S1, S2 or the FIFO holds one output slot, so the FIFO
    // can never be asked to take a beat it has no room for.
    assign w_credit_sum = {1'b0, w_fifo_count}
                        + {{CNT_W{1'b0}}, s1_q.valid}
                        + {{CNT_W{1'b0}}, s2_q.valid};
    assign w_sink_ready = ready_en_q && !w_fifo_full && (w_credit_sum < c_credit_limit);
    assign w_accept     = sink.valid && w_sink_ready;
    assign sink.ready   = w_sink_ready;

    assign fx_data_in    = fx_data_in_q;
    assign cfg_out       = cfg_q;
    assign dropped_beats = drop_q;

    // Packet classification, S1 load, config latch and drop counting
    always_comb begin
        state_d      = state_q;
        s1_d         = s1_q;
        s1_d.valid   = 1'b0;
        fx_data_in_d = fx_data_in_q;
        cfg_d        = cfg_q;
        drop_d       = drop_q;
        ready_en_d   = 1'b1;
        s2_d         = s1_q;

        if (w_accept) begin
            fx_data_in_d = sink.data;
            s1_d.data    = sink.data;
            s1_d.sop     = sink.startofpacket;
            s1_d.eop     = sink.endofpacket;

            if (sink.startofpacket) begin
                // A new sop always restarts classification, even mid-packet
                s1_d.valid  = 1'b1;
                s1_d.bypass = 1'b1;
                if (is_video_type(sink.data)) begin
                    cfg_d = cfg_in;
                end
                if (sink.endofpacket) begin
                    state_d = WAIT_SOP;
                end else if (is_video_type(sink.data)) begin
                    state_d = VIDEO;
                end else begin
                    state_d = CONTROL;
                end
            end else if (state_q == WAIT_SOP) begin
                // Orphan beat outside any packet: discard and count
                s1_d.valid = 1'b0;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end else begin
                s1_d.valid  = 1'b1;
                s1_d.bypass = (state_q == CONTROL);
                if (sink.endofpacket) begin
                    state_d = WAIT_SOP;
                end
            end
        end
    end

    // Pipeline, FSM and configuration registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= WAIT_SOP;
            s1_q         <= '0;
            s2_q         <= '0;
            fx_data_in_q <= '0;
            cfg_q        <= '0;
            drop_q       <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            fx_data_in_q <= fx_data_in_d;
            cfg_q        <= cfg_d;
            drop_q       <= drop_d;
            ready_en_q   <= ready_en_d;
        end
    end

    // S2 lines up with the effect's registered output
    assign w_fifo_wr_data = {s2_q.sop, s2_q.eop, (s2_q.bypass ? s2_q.data : fx_data_out)};
    assign w_fifo_pop     = !w_fifo_empty && source.ready;

    video_st_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (s2_q.valid),
        .wr_data (w_fifo_wr_data),
        .pop     (w_fifo_pop),
        .rd_data (w_fifo_rd_data),
        .count   (w_fifo_count),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full)
    );

    assign source.valid         = !w_fifo_empty;
    assign source.startofpacket = w_fifo_rd_data[BEAT_W-1];
    assign source.endofpacket   = w_fifo_rd_data[BEAT_W-2];
    assign source.data          = w_fifo_rd_data[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_video_effects_st_adapter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_video_effects_st_adapter
// Description : Scoreboard bench for video_effects_st_adapter with an
//               inverting effects-stage model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_effects_st_adapter;
    import video_fx_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    video_effects_st_adapter_if sink_if ();
    video_effects_st_adapter_if source_if ();

    logic [15:0]      fx_in;
    logic [15:0]      fx_out = 16'h0000;
    logic [CFG_W-1:0] cfg_in = '0;
    logic [CFG_W-1:0] cfg_out;
    logic [15:0]      dropped;

    video_effects_st_adapter #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .sink          (sink_if),
        .source        (source_if),
        .fx_data_in    (fx_in),
        .fx_data_out   (fx_out),
        .cfg_in        (cfg_in),
        .cfg_out       (cfg_out),
        .dropped_beats (dropped)
    );

    // Effects stage model: registered bitwise inversion
    always @(posedge clk) fx_out <= ~fx_in;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_fwd    = 0;
    int   n_pop    = 0;
    int   n_flush  = 0;
    int   first_edge = -1;
    int   hdr_edge   = 0;
    bit   bp_mode    = 1'b0;
    bit   ready_hold = 1'b1;
    bit   chk_credit = 1'b0;
    bit   lat_arm    = 1'b0;
    bit   rst_at_edge = 1'b1;
    bit   prev_stall  = 1'b0;
    logic [18:0] prev_out = '0;
    logic [17:0] exp_q [$];

    localparam logic [CFG_W-1:0] CFG_NEW = {5'b10000, 52'd0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_at_edge = !reset;
    end

    // Downstream ready: held level, or high one cycle in three
    always @(posedge clk) begin
        #1;
        source_if.ready = bp_mode ? (cyc % 3 == 0) : ready_hold;
    end

    // Monitor: credit rule, stall stability, latency capture, scoreboard pops
    always @(negedge clk) begin
        if (chk_credit)
            chk("credit_ready", {63'd0, sink_if.ready}, {63'd0, ((n_fwd - n_pop - n_flush) < 4)});
        if (prev_stall && !rst_at_edge)
            chk("stall_hold", {45'd0, source_if.valid, source_if.startofpacket,
                               source_if.endofpacket, source_if.data}, {45'd0, prev_out});
        if (lat_arm && source_if.valid) begin
            first_edge = cyc + 1;
            lat_arm = 1'b0;
        end
        if (source_if.valid && source_if.ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: got %0h expected none",
                         {source_if.startofpacket, source_if.endofpacket, source_if.data});
            end else begin
                chk("out_beat", {46'd0, source_if.startofpacket, source_if.endofpacket, source_if.data},
                    {46'd0, exp_q.pop_front()});
            end
            n_pop++;
        end
        prev_stall = source_if.valid && !source_if.ready;
        prev_out   = {source_if.valid, source_if.startofpacket, source_if.endofpacket, source_if.data};
    end

    // Offer one beat; on acceptance queue the expected output (if forwarded)
    task automatic send(input logic [15:0] d, input bit sop, input bit eop,
                        input bit fwd, input logic [15:0] exp_d);
        bit ok = 1'b0;
        sink_if.data          = d;
        sink_if.startofpacket = sop;
        sink_if.endofpacket   = eop;
        sink_if.valid         = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (sink_if.ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", d);
        end else if (fwd) begin
            exp_q.push_back({sop, eop, exp_d});
            n_fwd++;
        end
        sink_if.valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        sink_if.valid = 1'b0;
        sink_if.data = '0;
        sink_if.startofpacket = 1'b0;
        sink_if.endofpacket = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_source_valid", {63'd0, source_if.valid}, 64'd0);
        chk("rst_sink_ready", {63'd0, sink_if.ready}, 64'd0);
        chk("rst_cfg_out", {7'd0, cfg_out}, 64'd0);
        chk("rst_dropped", {48'd0, dropped}, 64'd0);
        chk("rst_fx_in", {48'd0, fx_in}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", {63'd0, sink_if.ready}, 64'd1);

        // Basic video packet
        lat_arm = 1'b1;
        send(16'h0000, 1, 0, 1, 16'h0000);
        hdr_edge = cyc;
        send(16'hF800, 0, 0, 1, 16'h07FF);
        send(16'h07E0, 0, 1, 1, 16'hF81F);
        wait_drain();
        chk("latency", 64'(first_edge), 64'(hdr_edge + 3));

        // Control packet bypass
        send(16'h000F, 1, 0, 1, 16'h000F);
        send(16'h1234, 0, 0, 1, 16'h1234);
        send(16'h5678, 0, 1, 1, 16'h5678);
        wait_drain();

        // Backpressure with 20 payload beats
        chk_credit = 1'b1;
        bp_mode = 1'b1;
        send(16'h0000, 1, 0, 1, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            logic [15:0] d;
            d = 16'hA000 | 16'(i);
            send(d, 0, (i == 19), 1, ~d);
        end
        wait_drain();
        bp_mode = 1'b0;
        chk_credit = 1'b0;
        @(posedge clk); #1;

        // Config latch only at a video sop
        send(16'h0000, 1, 0, 1, 16'h0000);
        send(16'h1111, 0, 0, 1, 16'hEEEE);
        cfg_in = CFG_NEW;
        send(16'h2222, 0, 0, 1, 16'hDDDD);
        chk("cfg_hold_mid", {7'd0, cfg_out}, 64'd0);
        send(16'h3333, 0, 1, 1, 16'hCCCC);
        chk("cfg_hold_eop", {7'd0, cfg_out}, 64'd0);
        send(16'h0000, 1, 0, 1, 16'h0000);
        chk("cfg_load_sop", {7'd0, cfg_out}, {7'd0, CFG_NEW});
        send(16'h4444, 0, 1, 1, 16'hBBBB);
        wait_drain();

        // Orphan beats
        chk("dropped_before", {48'd0, dropped}, 64'd0);
        send(16'hAAA1, 0, 0, 0, 16'h0000);
        send(16'hAAA2, 0, 0, 0, 16'h0000);
        send(16'hAAA3, 0, 1, 0, 16'h0000);
        send(16'h0000, 1, 1, 1, 16'h0000);
        chk("dropped_three", {48'd0, dropped}, 64'd3);
        wait_drain();

        // Reset mid-packet with beats in flight
        ready_hold = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        send(16'h0000, 1, 0, 1, 16'h0000);
        send(16'h1357, 0, 0, 1, 16'hECA8);
        send(16'h2468, 0, 0, 1, 16'hDB97);
        reset = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        n_flush = n_fwd - n_pop;
        reset = 1'b1;
        ready_hold = 1'b1;
        @(negedge clk);
        chk("midrst_source_valid", {63'd0, source_if.valid}, 64'd0);
        chk("midrst_sink_ready", {63'd0, sink_if.ready}, 64'd0);
        chk("midrst_cfg_out", {7'd0, cfg_out}, 64'd0);
        @(posedge clk); #1;
        send(16'h9999, 0, 0, 0, 16'h0000);
        send(16'h8888, 0, 1, 0, 16'h0000);
        chk("dropped_after_rst", {48'd0, dropped}, 64'd2);
        send(16'h0005, 1, 1, 1, 16'h0005);
        wait_drain();
        repeat (10) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_effects_st_adapter.md
# video_effects_st_adapter

Avalon-ST wrapper that lets the single-cycle, handshake-free `video_effects` pixel stage sit in the video pipeline. It accepts 16-bit RGB565 video packets from the upstream source and drives the effects stage's pixel input. It re-aligns `startofpacket`/`endofpacket` with the effects stage's registered output, and returns results downstream with full backpressure support. Header beats and control packets bypass the effects path. Effect configuration is latched once per video frame, so settings never change mid-frame (no tearing).

## Interface
- `FIFO_DEPTH`, default 4: output buffer entries. Must be a power of two and at least 4; 4 gives 1 beat/cycle throughput.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `sink_data`  in  16  upstream pixel/header data.
- `sink_startofpacket`, `sink_endofpacket`, `sink_valid`  in  1 each  Avalon-ST sink sideband.
- `sink_ready`  out  1  Avalon-ST sink ready.
- `source_data`  out  16  downstream data.
- `source_startofpacket`, `source_endofpacket`, `source_valid`  out  1 each  Avalon-ST source sideband.
- `source_ready`  in  1  downstream ready.
- `fx_data_in`  out  16  to effects stage pixel input.
- `fx_data_out`  in  16  from effects stage registered output (1-cycle latency).
- `cfg_in`  in  57  live effect config `{effect[4:0], delete_rgb[1:0], quantif_level[1:0], color_key[15:0], color_key_mask[15:0], color_substitute[15:0]}`, effect in MSBs.
- `cfg_out`  out  57  frame-latched config, same layout, wired to the effects stage config inputs.
- `dropped_beats`  out  16  saturating count of discarded beats.

## Operation
- A beat is accepted when `sink_valid && sink_ready`.
- Packet FSM (advances on accepted beats only):
  - `WAIT_SOP`:
    - beat without sop → discarded, `dropped_beats` +1 (saturates at 0xFFFF).
    - sop with `data[3:0]==0` → `VIDEO`.
    - sop with any other type → `CONTROL`.
  - `VIDEO` / `CONTROL`: eop → `WAIT_SOP`. sop → restart classification as above; the previous packet is left unterminated downstream.
  - sop+eop on the same beat: forward the single beat and stay in `WAIT_SOP`.
- Bypass flag:
  - set for every `CONTROL` beat and for any sop header beat;
  - clear for `VIDEO` payload beats.
- Stage 1 (S1), loaded on accept: `fx_data_in`, raw data, sop, eop, bypass, valid. When no beat is accepted, S1 valid clears and `fx_data_in` holds its last value.
- Stage 2 (S2): S1 sideband and raw data delayed one cycle, aligned with `fx_data_out`.
- FIFO write when S2 valid. Written data is S2 raw data if bypass, else `fx_data_out`.
- `cfg_out` loads `cfg_in` on the same edge that accepts a `VIDEO` sop beat. Otherwise `cfg_out` holds.
- Flow control: `sink_ready = (fifo_count + S1.valid + S2.valid) < FIFO_DEPTH`, computed combinationally from registers. This credit rule means the FIFO never overflows.
- Source side: `source_valid = !empty`, data/sop/eop taken from the FIFO head. Pop when `source_valid && source_ready`.
- Push and pop in the same cycle leave `fifo_count` unchanged.

## Timing
- Beat accepted at edge k: S1 at k, `fx_data_out` valid after k+1, FIFO write at k+2. Earliest `source_valid` is the cycle after k+2, i.e. 3 cycles latency.
- Steady-state throughput is 1 beat/cycle with `source_ready` held high.
- Reset (`reset==0` at an edge):
  - S1/S2 valid=0, FIFO empty, FSM `WAIT_SOP`;
  - `cfg_out`=0 (all effects off), `dropped_beats`=0;
  - `fx_data_in`=0, `sink_ready`=0.
  - On the first edge after release, `sink_ready` becomes 1.
- Reset mid-packet flushes all in-flight and buffered beats. Nothing partial is emitted afterwards; output resumes at the next sop.
- `source_*` outputs are unchanged while `source_valid && !source_ready`.

## Structure
- Shared package `video_fx_pkg`:
  - `cfg_in` field offsets and widths, total width 57;
  - FSM encoding `WAIT_SOP`/`VIDEO`/`CONTROL`;
  - `PKT_TYPE_VIDEO = 4'h0`.
- Sub-module `video_st_fifo`: synchronous FIFO, 18 bits wide (`{sop, eop, data}`), parameterised depth. It has push, pop, `count`, `empty` and `full` ports and uses the same clock/reset.
- The adapter holds the FSM, S1/S2, config latch, drop counter and credit logic. The effects stage is instantiated by the parent.

## Test plan
- **Basic video packet.** Send header 0x0000 (sop), pixels 0xF800, 0x07E0 (eop); bench effects model inverts its input; `source_ready`=1. Expect output 0x0000 (sop, bypassed), 0x07FF, 0xF81F (eop), with the first `source_valid` 3 cycles after the header is accepted.
- **Control packet bypass.** Send sop 0x000F, 0x1234, eop 0x5678 with the inverting model. Expect identical data out (0x000F, 0x1234, 0x5678) with sop/eop preserved.
- **Backpressure.** Stream 20 payload beats with `source_ready` toggling 1-of-3. Expect no loss or duplication, order preserved, `sink_ready` low whenever the credit sum reaches 4.
- **Config latch.** Change `cfg_in` from 0 to effect=5'b10000 mid-frame. Expect `cfg_out` unchanged until the next `VIDEO` sop is accepted, then equal to the new value on that same edge.
- **Orphan beats.** In `WAIT_SOP`, send 3 beats without sop, then sop+eop 0x0000. Expect `dropped_beats`=3 and a single output beat 0x0000 with sop=eop=1.
- **Reset mid-packet.** Assert `reset`=0 for 1 cycle with 3 beats in flight. Expect `source_valid`=0, `sink_ready`=0 and `cfg_out`=0 on the next cycle, with no stale beats emitted afterwards.
